// File: rtl/rx_word_sr_pkg.sv
// Shared types and helpers for the rx_word_sr receive shifter.
package rx_word_sr_pkg;

  localparam int RX_DEFAULT_WIDTH = 8;

  typedef enum logic {
    RX_EMPTY,
    RX_FULL
  } rx_hold_state_t;

  function automatic int rx_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/rx_word_sr_bit_counter.sv
// Rollover bit counter for rx_word_sr; rollover flags the final bit of a word.
module rx_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count,
  output logic             rollover
);

  logic [WIDTH-1:0] r_count;

  assign rollover = count_enable & (r_count == rollover_val);
  assign count    = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_enable) begin
      r_count <= rollover ? '0 : r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rx_word_sr.sv
// Parametrised serial-to-parallel I2C receive stage with a valid/ack holding register.
// Optional sticky overrun detection is built when RX_WORD_SR_OVERRUN_EN is defined.
module rx_word_sr
  import rx_word_sr_pkg::*;
#(
  parameter int DATA_WIDTH = RX_DEFAULT_WIDTH,
  parameter int MSB_FIRST  = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    sda_in,
  input  logic                                    rising_edge_found,
  input  logic                                    rx_enable,
  input  logic                                    clear,
  input  logic                                    data_ack,
  output logic [DATA_WIDTH-1:0]                   rx_shift,
  output logic [rx_cnt_width(DATA_WIDTH)-1:0]     bit_count,
  output logic [DATA_WIDTH-1:0]                   rx_data,
  output logic                                    rx_valid,
  output logic                                    word_done,
  output logic                                    overrun
);

  localparam int CNT_W = rx_cnt_width(DATA_WIDTH);

  logic                  r_shiftPulse;
  logic                  r_sdaQ;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_wordDone;
  rx_hold_state_t        r_state;
  rx_hold_state_t        w_stateNext;
  logic                  w_shift;
  logic                  w_rollover;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_nextShift;

  // Strobe and data are registered together so they stay aligned; clear drops the new strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shiftPulse <= 1'b0;
      r_sdaQ       <= 1'b0;
    end else begin
      r_shiftPulse <= rx_enable & rising_edge_found & ~clear;
      r_sdaQ       <= sda_in;
    end
  end

  assign w_shift = r_shiftPulse & ~clear;
  assign w_done  = w_shift & w_rollover;

  generate
    if (MSB_FIRST != 0) begin : g_msbFirst
      assign w_nextShift = {r_shift[DATA_WIDTH-2:0], r_sdaQ};
    end else begin : g_lsbFirst
      assign w_nextShift = {r_sdaQ, r_shift[DATA_WIDTH-1:1]};
    end
  endgenerate

  rx_bit_counter #(
    .WIDTH(CNT_W)
  ) u_bitCounter (
    .clk         (clk),
    .rst         (rst),
    .count_enable(w_shift),
    .clear       (clear),
    .rollover_val(CNT_W'(DATA_WIDTH - 1)),
    .count       (bit_count),
    .rollover    (w_rollover)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_data     <= '0;
      r_wordDone <= 1'b0;
    end else begin
      r_wordDone <= w_done;
      if (clear) begin
        r_shift <= '0;
      end else if (w_shift) begin
        r_shift <= w_nextShift;
      end
      if (w_done) begin
        r_data <= w_nextShift;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RX_EMPTY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // A completion landing together with an ack keeps the register full with the new word.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      RX_EMPTY: if (w_done) w_stateNext = RX_FULL;
      RX_FULL:  if (!w_done && data_ack) w_stateNext = RX_EMPTY;
      default:  w_stateNext = RX_EMPTY;
    endcase
  end

`ifdef RX_WORD_SR_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_overrun <= 1'b0;
    end else if (w_done && (r_state == RX_FULL) && !data_ack) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

  assign rx_shift  = r_shift;
  assign rx_data   = r_data;
  assign rx_valid  = (r_state == RX_FULL);
  assign word_done = r_wordDone;

endmodule

// File: tb/tb_rx_word_sr.sv
// Self-checking bench for rx_word_sr: three instances (8-bit MSB, 8-bit LSB, 12-bit MSB)
// driven from shared inputs and compared every cycle against a bit-history model.
module tb_rx_word_sr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sdaIn = 1'b0;
  logic edgeFound = 1'b0;
  logic rxEnable = 1'b0;
  logic clearIn = 1'b0;
  logic dataAck = 1'b0;

  logic [7:0]  shift0, data0;
  logic [3:0]  cnt0;
  logic        valid0, done0, ovr0;
  logic [7:0]  shift1, data1;
  logic [3:0]  cnt1;
  logic        valid1, done1, ovr1;
  logic [11:0] shift2, data2;
  logic [3:0]  cnt2;
  logic        valid2, done2, ovr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_word_sr #(.DATA_WIDTH(8), .MSB_FIRST(1)) dutMsb (
    .clk(clk), .rst(rst), .sda_in(sdaIn), .rising_edge_found(edgeFound),
    .rx_enable(rxEnable), .clear(clearIn), .data_ack(dataAck),
    .rx_shift(shift0), .bit_count(cnt0), .rx_data(data0),
    .rx_valid(valid0), .word_done(done0), .overrun(ovr0));

  rx_word_sr #(.DATA_WIDTH(8), .MSB_FIRST(0)) dutLsb (
    .clk(clk), .rst(rst), .sda_in(sdaIn), .rising_edge_found(edgeFound),
    .rx_enable(rxEnable), .clear(clearIn), .data_ack(dataAck),
    .rx_shift(shift1), .bit_count(cnt1), .rx_data(data1),
    .rx_valid(valid1), .word_done(done1), .overrun(ovr1));

  rx_word_sr #(.DATA_WIDTH(12), .MSB_FIRST(1)) dutW12 (
    .clk(clk), .rst(rst), .sda_in(sdaIn), .rising_edge_found(edgeFound),
    .rx_enable(rxEnable), .clear(clearIn), .data_ack(dataAck),
    .rx_shift(shift2), .bit_count(cnt2), .rx_data(data2),
    .rx_valid(valid2), .word_done(done2), .overrun(ovr2));

  // Model: per instance, the most recent received bits (index 0 = newest) since clear/reset.
  int mW[3]   = '{8, 8, 12};
  int mMsb[3] = '{1, 0, 1};
  bit mHist[3][12];
  int mCnt[3];
  int mData[3];
  bit mValid[3], mDone[3], mOvr[3], mPend[3], mPendSda[3];

  function automatic int modelShift(input int i);
    int v = 0;
    for (int a = 0; a < mW[i]; a++) begin
      if (mHist[i][a]) v += (mMsb[i] != 0) ? (1 << a) : (1 << (mW[i] - 1 - a));
    end
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 12; k++) mHist[i][k] = 1'b0;
      mCnt[i] = 0; mData[i] = 0;
      mValid[i] = 0; mDone[i] = 0; mOvr[i] = 0; mPend[i] = 0; mPendSda[i] = 0;
    end
  endtask

  task automatic modelStep(input bit sda, input bit edg, input bit en, input bit clr, input bit ack);
    for (int i = 0; i < 3; i++) begin
      bit complete = 1'b0;
      int word = 0;
      mDone[i] = 1'b0;
      if (mPend[i] && !clr) begin
        for (int k = 11; k > 0; k--) mHist[i][k] = mHist[i][k-1];
        mHist[i][0] = mPendSda[i];
        mCnt[i]++;
        if (mCnt[i] == mW[i]) begin
          mCnt[i] = 0;
          complete = 1'b1;
          word = modelShift(i);
        end
      end
      if (clr) begin
        for (int k = 0; k < 12; k++) mHist[i][k] = 1'b0;
        mCnt[i] = 0;
        mOvr[i] = 1'b0;
      end
      if (complete) begin
`ifdef RX_WORD_SR_OVERRUN_EN
        if (mValid[i] && !ack) mOvr[i] = 1'b1;
`endif
        mData[i] = word;
        mValid[i] = 1'b1;
        mDone[i] = 1'b1;
      end else if (ack) begin
        mValid[i] = 1'b0;
      end
      mPend[i] = en && edg && !clr;
      mPendSda[i] = sda;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compareInst(input int i, input string name, input logic [31:0] s,
                             input logic [31:0] c, input logic [31:0] d,
                             input logic v, input logic w, input logic o);
    checkOutput({name, " rx_shift"}, s, 32'(modelShift(i)));
    checkOutput({name, " bit_count"}, c, 32'(mCnt[i]));
    checkOutput({name, " rx_data"}, d, 32'(mData[i]));
    checkOutput({name, " rx_valid"}, 32'(v), 32'(mValid[i]));
    checkOutput({name, " word_done"}, 32'(w), 32'(mDone[i]));
    checkOutput({name, " overrun"}, 32'(o), 32'(mOvr[i]));
  endtask

  task automatic compareAll();
    compareInst(0, "msb8", 32'(shift0), 32'(cnt0), 32'(data0), valid0, done0, ovr0);
    compareInst(1, "lsb8", 32'(shift1), 32'(cnt1), 32'(data1), valid1, done1, ovr1);
    compareInst(2, "msb12", 32'(shift2), 32'(cnt2), 32'(data2), valid2, done2, ovr2);
  endtask

  // One clock: drive inputs after the falling edge, step the model at the rising edge, check.
  task automatic applyStimulus(input bit sda, input bit edg, input bit en, input bit clr, input bit ack);
    sdaIn = sda; edgeFound = edg; rxEnable = en; clearIn = clr; dataAck = ack;
    @(posedge clk);
    modelStep(sda, edg, en, clr, ack);
    @(negedge clk);
    compareAll();
  endtask

  task automatic sendStream(input logic [15:0] v, input int n, input bit ackLast);
    for (int k = n - 1; k >= 0; k--) begin
      applyStimulus(v[k], 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, (k == 0) && ackLast);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic doClear();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic doAck();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    compareAll();
    rst = 1'b0;

    $display("[TB] MSB/LSB first word A5");
    sendStream(16'h00A5, 8, 1'b0);
    checkOutput("t1 msb data", 32'(data0), 32'h A5);
    checkOutput("t1 lsb data", 32'(data1), 32'h A5);
    checkOutput("t1 msb valid", 32'(valid0), 32'h1);
    doAck();

    $display("[TB] stream 11000000");
    doClear();
    sendStream(16'h00C0, 8, 1'b0);
    checkOutput("t2 msb data", 32'(data0), 32'h C0);
    checkOutput("t2 lsb data", 32'(data1), 32'h 03);
    doAck();

    $display("[TB] gated and aborted word");
    doClear();
    sendStream(16'h0005, 3, 1'b0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("t3 gated count", 32'(cnt0), 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t3 clear count", 32'(cnt0), 32'd0);
    checkOutput("t3 clear shift", 32'(shift0), 32'd0);
    checkOutput("t3 data kept", 32'(data0), 32'h C0);

    $display("[TB] handshake collision");
    doClear();
    sendStream(16'h003C, 8, 1'b0);
    sendStream(16'h00C3, 8, 1'b1);
    checkOutput("t4 valid", 32'(valid0), 32'h1);
    checkOutput("t4 data", 32'(data0), 32'h C3);
    checkOutput("t4 no overrun", 32'(ovr0), 32'h0);

    $display("[TB] overrun");
    doClear();
    doAck();
    sendStream(16'h005A, 8, 1'b0);
    sendStream(16'h0096, 8, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef RX_WORD_SR_OVERRUN_EN
    checkOutput("t5 overrun", 32'(ovr0), 32'h1);
`else
    checkOutput("t5 overrun", 32'(ovr0), 32'h0);
`endif
    checkOutput("t5 newest data", 32'(data0), 32'h96);
    doClear();
    checkOutput("t5 overrun cleared", 32'(ovr0), 32'h0);

    $display("[TB] width 12 and reset");
    doAck();
    sendStream(16'h0016, 5, 1'b0);
    #2 rst = 1'b1;
    #1 modelReset();
    compareAll();
    checkOutput("t6 reset count", 32'(cnt2), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    compareAll();
    sendStream(16'h0F0A, 12, 1'b0);
    checkOutput("t6 w12 data", 32'(data2), 32'h F0A);
    checkOutput("t6 w12 wrap", 32'(cnt2), 32'd0);
    checkOutput("t6 w12 valid", 32'(valid2), 32'h1);

    $display("[TB] random traffic");
    for (int n = 0; n < 800; n++) begin
      applyStimulus(1'($urandom % 2), ($urandom % 3) == 0, ($urandom % 8) != 0,
                    ($urandom % 60) == 0, ($urandom % 6) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
